// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with load-use hazard detection.
//
// Purpose:
//   Registers the decode-stage control fields, operands and register indices
//   into the EX stage. A load in EX whose destination is read by the
//   instruction in decode raises Stall for one cycle and inserts a bubble.
//   A taken branch/jump resolved in EX (Flush) kills the instruction entering
//   EX and has priority over the stall. StallCount saturates at 16'hFFFF.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   *_d               decode-stage control bits/fields, PC, operands, indices
//   Flush             kill the instruction entering EX
//   *_ex              registered copies of every *_d input (one-clock latency)
//   Valid_ex          EX slot holds a real instruction (0 = bubble)
//   Stall             combinational load-use stall request (holds PC, IF/ID)
//   StallCount        saturating count of clock edges taken with Stall=1
//
// Handshake: there is no valid/ready pair. On every rising edge the slot either
// captures the decode inputs (Flush=0, Stall=0) or is cleared to a bubble.

module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ALUASrc_d,
  input  logic        ALUBSrc_d,
  input  logic        DMWr_d,
  input  logic        RUWr_d,
  input  logic        DMRd_d,
  input  logic [3:0]  ALUOp_d,
  input  logic [4:0]  BrOp_d,
  input  logic [2:0]  DMCtrl_d,
  input  logic [1:0]  RUDATAWrSrc_d,
  input  logic [31:0] PC_d,
  input  logic [31:0] RUrs1_d,
  input  logic [31:0] RUrs2_d,
  input  logic [31:0] ImmExt_d,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_d,
  input  logic        Flush,
  output logic        ALUASrc_ex,
  output logic        ALUBSrc_ex,
  output logic        DMWr_ex,
  output logic        RUWr_ex,
  output logic        DMRd_ex,
  output logic [3:0]  ALUOp_ex,
  output logic [4:0]  BrOp_ex,
  output logic [2:0]  DMCtrl_ex,
  output logic [1:0]  RUDATAWrSrc_ex,
  output logic [31:0] PC_ex,
  output logic [31:0] RUrs1_ex,
  output logic [31:0] RUrs2_ex,
  output logic [31:0] ImmExt_ex,
  output logic [4:0]  rs1_ex,
  output logic [4:0]  rs2_ex,
  output logic [4:0]  rd_ex,
  output logic        Valid_ex,
  output logic        Stall,
  output logic [15:0] StallCount
);

  typedef struct packed {
    logic        alua_src;
    logic        alub_src;
    logic        dm_wr;
    logic        ru_wr;
    logic        dm_rd;
    logic [3:0]  alu_op;
    logic [4:0]  br_op;
    logic [2:0]  dm_ctrl;
    logic [1:0]  ru_data_wr_src;
    logic [31:0] pc;
    logic [31:0] ru_rs1;
    logic [31:0] ru_rs2;
    logic [31:0] imm_ext;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } ex_slot_t;

  ex_slot_t    dec_slot;
  ex_slot_t    ex_d, ex_q;
  logic        valid_d, valid_q;
  logic [15:0] stall_count_d, stall_count_q;
  logic        load_use;
  logic        bubble;

  always_comb begin
    dec_slot = {ALUASrc_d, ALUBSrc_d, DMWr_d, RUWr_d, DMRd_d, ALUOp_d, BrOp_d,
                DMCtrl_d, RUDATAWrSrc_d, PC_d, RUrs1_d, RUrs2_d, ImmExt_d,
                rs1_d, rs2_d, rd_d};

    // Only registered state feeds the hazard check, so reset clears Stall.
    // x0 is never a real producer, hence the rd != 0 term.
    load_use = ex_q.dm_rd && valid_q && (ex_q.rd != 5'd0) &&
               ((ex_q.rd == rs1_d) || (ex_q.rd == rs2_d));

    // Flush wins: the stalled consumer is on the wrong path anyway.
    Stall  = load_use && !Flush;
    bubble = Flush || Stall;

    ex_d    = bubble ? ex_slot_t'('0) : dec_slot;
    valid_d = !bubble;

    stall_count_d = stall_count_q;
    if (Stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q          <= '0;
      valid_q       <= 1'b0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      valid_q       <= valid_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ALUASrc_ex     = ex_q.alua_src;
  assign ALUBSrc_ex     = ex_q.alub_src;
  assign DMWr_ex        = ex_q.dm_wr;
  assign RUWr_ex        = ex_q.ru_wr;
  assign DMRd_ex        = ex_q.dm_rd;
  assign ALUOp_ex       = ex_q.alu_op;
  assign BrOp_ex        = ex_q.br_op;
  assign DMCtrl_ex      = ex_q.dm_ctrl;
  assign RUDATAWrSrc_ex = ex_q.ru_data_wr_src;
  assign PC_ex          = ex_q.pc;
  assign RUrs1_ex       = ex_q.ru_rs1;
  assign RUrs2_ex       = ex_q.ru_rs2;
  assign ImmExt_ex      = ex_q.imm_ext;
  assign rs1_ex         = ex_q.rs1;
  assign rs2_ex         = ex_q.rs2;
  assign rd_ex          = ex_q.rd;
  assign Valid_ex       = valid_q;
  assign StallCount     = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage -- directed table-driven bench for id_ex_stage.

module tb_id_ex_stage;

  typedef struct packed {
    logic        alua_src;
    logic        alub_src;
    logic        dm_wr;
    logic        ru_wr;
    logic        dm_rd;
    logic [3:0]  alu_op;
    logic [4:0]  br_op;
    logic [2:0]  dm_ctrl;
    logic [1:0]  wr_src;
    logic [31:0] pc;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } dec_t;

  typedef struct {
    string       name;
    dec_t        din;
    logic        flush;
    logic        exp_stall;  // Stall before the edge
    logic        exp_adv;    // 1: slot takes din, 0: bubble
    logic [15:0] exp_cnt;    // StallCount after the edge
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        ALUASrc_d, ALUBSrc_d, DMWr_d, RUWr_d, DMRd_d;
  logic [3:0]  ALUOp_d;
  logic [4:0]  BrOp_d;
  logic [2:0]  DMCtrl_d;
  logic [1:0]  RUDATAWrSrc_d;
  logic [31:0] PC_d, RUrs1_d, RUrs2_d, ImmExt_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        Flush;
  logic        ALUASrc_ex, ALUBSrc_ex, DMWr_ex, RUWr_ex, DMRd_ex;
  logic [3:0]  ALUOp_ex;
  logic [4:0]  BrOp_ex;
  logic [2:0]  DMCtrl_ex;
  logic [1:0]  RUDATAWrSrc_ex;
  logic [31:0] PC_ex, RUrs1_ex, RUrs2_ex, ImmExt_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic        Valid_ex, Stall;
  logic [15:0] StallCount;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .ALUASrc_d(ALUASrc_d), .ALUBSrc_d(ALUBSrc_d), .DMWr_d(DMWr_d),
    .RUWr_d(RUWr_d), .DMRd_d(DMRd_d), .ALUOp_d(ALUOp_d), .BrOp_d(BrOp_d),
    .DMCtrl_d(DMCtrl_d), .RUDATAWrSrc_d(RUDATAWrSrc_d), .PC_d(PC_d),
    .RUrs1_d(RUrs1_d), .RUrs2_d(RUrs2_d), .ImmExt_d(ImmExt_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .Flush(Flush),
    .ALUASrc_ex(ALUASrc_ex), .ALUBSrc_ex(ALUBSrc_ex), .DMWr_ex(DMWr_ex),
    .RUWr_ex(RUWr_ex), .DMRd_ex(DMRd_ex), .ALUOp_ex(ALUOp_ex),
    .BrOp_ex(BrOp_ex), .DMCtrl_ex(DMCtrl_ex), .RUDATAWrSrc_ex(RUDATAWrSrc_ex),
    .PC_ex(PC_ex), .RUrs1_ex(RUrs1_ex), .RUrs2_ex(RUrs2_ex),
    .ImmExt_ex(ImmExt_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .Valid_ex(Valid_ex), .Stall(Stall), .StallCount(StallCount)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [161:0] act, input logic [161:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input dec_t d, input logic fl);
    {ALUASrc_d, ALUBSrc_d, DMWr_d, RUWr_d, DMRd_d, ALUOp_d, BrOp_d, DMCtrl_d,
     RUDATAWrSrc_d, PC_d, RUrs1_d, RUrs2_d, ImmExt_d, rs1_d, rs2_d, rd_d} = d;
    Flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic dec_t ex_out();
    return {ALUASrc_ex, ALUBSrc_ex, DMWr_ex, RUWr_ex, DMRd_ex, ALUOp_ex, BrOp_ex,
            DMCtrl_ex, RUDATAWrSrc_ex, PC_ex, RUrs1_ex, RUrs2_ex, ImmExt_ex,
            rs1_ex, rs2_ex, rd_ex};
  endfunction

  // Plain instruction with operand values derived from the PC.
  function automatic dec_t op(input logic [31:0] pc, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic dm_rd, input logic ru_wr);
    dec_t d;
    d       = '0;
    d.pc    = pc;
    d.rs1_v = pc ^ 32'h1111_0000;
    d.rs2_v = pc ^ 32'h0000_2222;
    d.imm   = pc + 32'd4;
    d.rs1   = rs1;
    d.rs2   = rs2;
    d.rd    = rd;
    d.dm_rd = dm_rd;
    d.ru_wr = ru_wr;
    if (dm_rd) begin
      d.dm_ctrl = 3'b010;
      d.wr_src  = 2'b01;
    end
    return d;
  endfunction

  vec_t vt[15];

  initial begin
    dec_t d;
    dec_t ld;
    dec_t dep;

    // ---------- reset with no clock edge ----------
    rst = 1'b1;
    d = '0;
    d.pc = 32'h40;
    d.ru_wr = 1'b1;
    drive(d, 1'b0);
    #2;
    chk("rst_pc_ex", PC_ex, 32'h0);
    chk("rst_ruwr_ex", RUWr_ex, 1'b0);
    chk("rst_valid", Valid_ex, 1'b0);
    chk("rst_count", StallCount, 16'h0);
    chk("rst_stall", Stall, 1'b0);
    chk("rst_bundle", ex_out(), '0);
    tick();
    rst = 1'b0;

    // ---------- vector table ----------
    d = op(32'h100, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
    d.alu_op = 4'b1000;
    d.imm = 32'hFFFF_FFF0;
    vt[0] = '{"advance", d, 1'b0, 1'b0, 1'b1, 16'd0};
    vt[1] = '{"load_rd7", op(32'h104, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1), 1'b0, 1'b0, 1'b1, 16'd0};
    d = op(32'h108, 5'd3, 5'd7, 5'd8, 1'b0, 1'b1);
    d.alu_op = 4'b0001;
    vt[2] = '{"use_rs2_stall", d, 1'b0, 1'b1, 1'b0, 16'd1};
    vt[3] = '{"use_rs2_release", d, 1'b0, 1'b0, 1'b1, 16'd1};
    vt[4] = '{"load_rd0", op(32'h10C, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1, 16'd1};
    vt[5] = '{"x0_no_stall", op(32'h110, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1, 16'd1};
    vt[6] = '{"load_rd3", op(32'h114, 5'd9, 5'd1, 5'd3, 1'b1, 1'b1), 1'b0, 1'b0, 1'b1, 16'd1};
    d = op(32'h118, 5'd3, 5'd1, 5'd11, 1'b0, 1'b1);
    d.dm_wr = 1'b1;
    d.br_op = 5'b10001;
    vt[7] = '{"flush_over_stall", d, 1'b1, 1'b0, 1'b0, 16'd1};
    vt[8] = '{"load_rd4_self", op(32'h11C, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1), 1'b0, 1'b0, 1'b1, 16'd1};
    d = op(32'h120, 5'd4, 5'd4, 5'd10, 1'b0, 1'b0);
    d.br_op = 5'b01000;
    vt[9]  = '{"use_both_stall", d, 1'b0, 1'b1, 1'b0, 16'd2};
    vt[10] = '{"use_both_release", d, 1'b0, 1'b0, 1'b1, 16'd2};
    d = op(32'h200, 5'd2, 5'd3, 5'd12, 1'b0, 1'b1);
    d.dm_wr = 1'b1;
    vt[11] = '{"flush_plain", d, 1'b1, 1'b0, 1'b0, 16'd2};
    d = '1;
    d.pc = 32'hFFFF_FFFC;
    vt[12] = '{"all_ones", d, 1'b0, 1'b0, 1'b1, 16'd2};
    d = op(32'h204, 5'd31, 5'd1, 5'd13, 1'b0, 1'b1);
    vt[13] = '{"use_rs1_stall", d, 1'b0, 1'b1, 1'b0, 16'd3};
    vt[14] = '{"use_rs1_release", d, 1'b0, 1'b0, 1'b1, 16'd3};

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].din, vt[i].flush);
      #1;
      chk({vt[i].name, "_stall"}, Stall, vt[i].exp_stall);
      tick();
      chk({vt[i].name, "_valid"}, Valid_ex, vt[i].exp_adv);
      chk({vt[i].name, "_slot"}, ex_out(), vt[i].exp_adv ? vt[i].din : dec_t'('0));
      chk({vt[i].name, "_count"}, StallCount, vt[i].exp_cnt);
    end

    // ---------- reset asserted mid-stall ----------
    ld  = op(32'h300, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1);
    dep = op(32'h304, 5'd5, 5'd12, 5'd14, 1'b0, 1'b1);
    drive(ld, 1'b0);
    tick();
    drive(dep, 1'b0);
    #1;
    chk("midrst_pre_stall", Stall, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", Stall, 1'b0);
    chk("midrst_valid", Valid_ex, 1'b0);
    chk("midrst_count", StallCount, 16'h0);
    chk("midrst_slot", ex_out(), '0);
    tick();
    rst = 1'b0;
    #1;
    chk("postrst_stall", Stall, 1'b0);
    tick();
    chk("postrst_valid", Valid_ex, 1'b1);
    chk("postrst_slot", ex_out(), dep);

    // ---------- saturation ----------
    force dut.stall_count_q = 16'hFFFE;
    #1;
    release dut.stall_count_q;
    ld  = op(32'h400, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1);
    dep = op(32'h404, 5'd6, 5'd0, 5'd15, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(ld, 1'b0);
      tick();
      chk($sformatf("sat%0d_load_count", k), StallCount, (k == 0) ? 16'hFFFE : 16'hFFFF);
      drive(dep, 1'b0);
      #1;
      chk($sformatf("sat%0d_stall", k), Stall, 1'b1);
      tick();
      chk($sformatf("sat%0d_valid", k), Valid_ex, 1'b0);
      chk($sformatf("sat%0d_count", k), StallCount, 16'hFFFF);
    end
    drive(dep, 1'b0);
    tick();
    chk("sat_hold_count", StallCount, 16'hFFFF);
    chk("sat_hold_slot", ex_out(), dep);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
